// File: rtl/apb_event_sink.sv
// APB completer: accumulates event counts written to three report registers, readable back over APB.
// Optional macro APB_SINK_SATURATE_EN: saturating accumulate; writing 0 clears a saturated total.
module apb_event_sink #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] ADDR_A      = 32'hABBA0000,
   parameter logic [31:0] ADDR_B      = 32'hBAFF0000,
   parameter logic [31:0] ADDR_C      = 32'hCAFE0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        apb_psel_i,
   input  logic        apb_penable_i,
   input  logic [31:0] apb_paddr_i,
   input  logic        apb_pwrite_i,
   input  logic [31:0] apb_pwdata_i,
   output logic        apb_pready_o,
   output logic [31:0] apb_prdata_o,
   output logic        apb_pslverr_o,
   output logic [31:0] a_total_o,
   output logic [31:0] b_total_o,
   output logic [31:0] c_total_o,
   output logic [2:0]  wr_strobe_o,
   output logic        proto_err_o
);
   localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]      r_addr;
   logic             r_write;
   logic [2:0][31:0] r_total;
   logic [2:0]       r_strobe;
   logic             r_proto_err;

   logic             w_latch, w_commit, w_proto_set, w_done;
   logic [2:0]       w_sel;
   logic [31:0]      w_sel_total, w_sum;

   // One-hot {C,B,A} decode of the address latched at SETUP; all-zero means unmapped.
   assign w_sel  = {r_addr == ADDR_C, r_addr == ADDR_B, r_addr == ADDR_A};
   assign w_done = (r_state == S_ACCESS) && (r_cnt == '0);

   always_comb begin
      w_sel_total = '0;
      for (int i = 0; i < 3; i++)
         if (w_sel[i]) w_sel_total = w_sel_total | r_total[i];
   end

`ifdef APB_SINK_SATURATE_EN
   logic [32:0] w_sum_wide;
   assign w_sum_wide = {1'b0, w_sel_total} + {1'b0, apb_pwdata_i};

   always_comb begin
      if ((&w_sel_total) && (apb_pwdata_i == '0)) w_sum = '0;
      else if (w_sum_wide[32])                    w_sum = '1;
      else                                        w_sum = w_sum_wide[31:0];
   end
`else
   assign w_sum = w_sel_total + apb_pwdata_i;
`endif

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_commit    = 1'b0;
      w_proto_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (apb_psel_i && !apb_penable_i) begin
               w_state_nxt = S_ACCESS;
               w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
               w_latch     = 1'b1;
            end else if (apb_psel_i && apb_penable_i) begin
               w_proto_set = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!apb_psel_i) begin
               w_state_nxt = S_IDLE;
               w_proto_set = 1'b1;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (apb_penable_i) begin
               w_state_nxt = S_IDLE;
               w_commit    = 1'b1;
            end else begin
               // Master re-issued SETUP when ACCESS was due: drop the transfer.
               w_state_nxt = S_IDLE;
               w_proto_set = 1'b1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_total     <= '0;
         r_strobe    <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_strobe <= (w_commit && r_write) ? w_sel : 3'b000;
         if (w_proto_set) r_proto_err <= 1'b1;
         for (int i = 0; i < 3; i++)
            if (w_commit && r_write && w_sel[i]) r_total[i] <= w_sum;
      end
   end

   // NOTE: the address/direction latches carry no reset; they are only decoded while in S_ACCESS.
   always_ff @(posedge clk) begin
      if (w_latch) begin
         r_addr  <= apb_paddr_i;
         r_write <= apb_pwrite_i;
      end
   end

   assign apb_pready_o  = w_done;
   assign apb_pslverr_o = w_done && (w_sel == 3'b000);
   assign apb_prdata_o  = (w_done && !r_write) ? w_sel_total : 32'h0;
   assign a_total_o     = r_total[0];
   assign b_total_o     = r_total[1];
   assign c_total_o     = r_total[2];
   assign wr_strobe_o   = r_strobe;
   assign proto_err_o   = r_proto_err;

endmodule

// File: tb/tb_apb_event_sink.sv
// Bench for apb_event_sink: three instances (0, 2 and 3 wait states) checked against a queue-free
// behavioural model of per-event totals; honours APB_SINK_SATURATE_EN in the model.
module tb_apb_event_sink;
   localparam int N      = 3;
   localparam int BUDGET = 16;
   localparam logic [31:0] ADDR_A = 32'hABBA0000;
   localparam logic [31:0] ADDR_B = 32'hBAFF0000;
   localparam logic [31:0] ADDR_C = 32'hCAFE0000;

   typedef struct packed {
      logic [7:0]  lat;
      logic        rdy;
      logic        quiet;
      logic        idle_after;
      logic [31:0] rdata;
      logic        err;
      logic [2:0]  strobe;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        perr;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel    [N];
   logic        penable [N];
   logic [31:0] paddr   [N];
   logic        pwrite  [N];
   logic [31:0] pwdata  [N];
   logic        pready  [N];
   logic [31:0] prdata  [N];
   logic        pslverr [N];
   logic [31:0] a_tot   [N];
   logic [31:0] b_tot   [N];
   logic [31:0] c_tot   [N];
   logic [2:0]  strobe  [N];
   logic        perr    [N];

   logic [31:0] m_tot  [N][3];
   logic        m_perr [N];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      apb_event_sink #(.WAIT_CYCLES((g == 0) ? 0 : g + 1)) u_dut (
         .clk           (clk),
         .reset         (reset),
         .apb_psel_i    (psel[g]),
         .apb_penable_i (penable[g]),
         .apb_paddr_i   (paddr[g]),
         .apb_pwrite_i  (pwrite[g]),
         .apb_pwdata_i  (pwdata[g]),
         .apb_pready_o  (pready[g]),
         .apb_prdata_o  (prdata[g]),
         .apb_pslverr_o (pslverr[g]),
         .a_total_o     (a_tot[g]),
         .b_total_o     (b_tot[g]),
         .c_total_o     (c_tot[g]),
         .wr_strobe_o   (strobe[g]),
         .proto_err_o   (perr[g])
      );
   end

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : d + 1;
   endfunction

   function automatic int decode(input logic [31:0] a);
      if (a == ADDR_A) return 0;
      if (a == ADDR_B) return 1;
      if (a == ADDR_C) return 2;
      return -1;
   endfunction

   function automatic logic [31:0] acc(input logic [31:0] t, input logic [31:0] v);
      logic [63:0] s;
      s = 64'(t) + 64'(v);
`ifdef APB_SINK_SATURATE_EN
      if (t == 32'hFFFFFFFF && v == 32'h0) return 32'h0;
      if (s > 64'hFFFFFFFF) return 32'hFFFFFFFF;
`endif
      return s[31:0];
   endfunction

   function automatic string show(input obs_t o);
      return $sformatf("lat=%0d rdy=%b quiet=%b idle=%b rd=%h err=%b stb=%b a=%h b=%h c=%h perr=%b",
                       o.lat, o.rdy, o.quiet, o.idle_after, o.rdata, o.err, o.strobe, o.a, o.b, o.c, o.perr);
   endfunction

   task automatic model_clear();
      for (int d = 0; d < N; d++) begin
         m_perr[d] = 1'b0;
         for (int k = 0; k < 3; k++) m_tot[d][k] = 32'h0;
      end
   endtask

   // Expected outcome of one complete transfer; updates the model totals.
   task automatic model_xfer(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output obs_t e);
      int k;
      k = decode(addr);
      e = '0;
      e.lat        = 8'(wait_of(d) + 1);
      e.rdy        = 1'b1;
      e.quiet      = 1'b1;
      e.idle_after = 1'b1;
      if (k < 0) e.err = 1'b1;
      else if (wr) begin
         e.strobe    = 3'(1 << k);
         m_tot[d][k] = acc(m_tot[d][k], data);
      end else e.rdata = m_tot[d][k];
      e.a    = m_tot[d][0];
      e.b    = m_tot[d][1];
      e.c    = m_tot[d][2];
      e.perr = m_perr[d];
   endtask

   // Drives one APB transfer starting at the current negedge; ends on the negedge after completion.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, output obs_t o);
      o = '0;
      o.quiet    = 1'b1;
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = data;
      @(negedge clk);
      penable[d] = 1'b1;
      o.lat      = 8'd1;
      while (pready[d] !== 1'b1 && o.lat < 8'(BUDGET)) begin
         if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) o.quiet = 1'b0;
         @(negedge clk);
         o.lat++;
      end
      o.rdy   = pready[d];
      o.rdata = wr ? 32'h0 : prdata[d];
      o.err   = pslverr[d];
      @(negedge clk);
      o.strobe     = strobe[d];
      o.idle_after = (pready[d] === 1'b0) && (pslverr[d] === 1'b0) && (prdata[d] === 32'h0);
      o.a          = a_tot[d];
      o.b          = b_tot[d];
      o.c          = c_tot[d];
      o.perr       = perr[d];
      psel[d]      = 1'b0;
      penable[d]   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         n_cmp++;
         if ({pready[d], pslverr[d], prdata[d], a_tot[d], b_tot[d], c_tot[d], strobe[d], perr[d]} !== '0) begin
            n_err++;
            $display("FAIL reset_d%0d: got rdy=%b err=%b rd=%h a=%h b=%h c=%h stb=%b perr=%b, want all zero",
                     d, pready[d], pslverr[d], prdata[d], a_tot[d], b_tot[d], c_tot[d], strobe[d], perr[d]);
         end
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_basic_write();
      obs_t o, e;
      xfer(0, 1'b1, ADDR_A, 32'd5, o);
      model_xfer(0, 1'b1, ADDR_A, 32'd5, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_w5: got %s want %s", show(o), show(e)); end
      xfer(0, 1'b1, ADDR_A, 32'd3, o);
      model_xfer(0, 1'b1, ADDR_A, 32'd3, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL basic_w3: got %s want %s", show(o), show(e)); end
      n_cmp++;
      if (o.a !== 32'd8 || o.strobe !== 3'b001 || o.lat !== 8'd1) begin
         n_err++;
         $display("FAIL basic_total: got a=%h stb=%b lat=%0d want a=00000008 stb=001 lat=1", o.a, o.strobe, o.lat);
      end
   endtask

   task automatic test_wait_states();
      obs_t o, e;
      @(negedge clk);
      xfer(1, 1'b1, ADDR_C, 32'd7, o);
      model_xfer(1, 1'b1, ADDR_C, 32'd7, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL wait_w7: got %s want %s", show(o), show(e)); end
      n_cmp++;
      if (o.lat !== 8'd3 || o.c !== 32'd7) begin
         n_err++; $display("FAIL wait_lat: got lat=%0d c=%h want lat=3 c=00000007", o.lat, o.c);
      end
      xfer(1, 1'b0, ADDR_C, 32'd0, o);
      model_xfer(1, 1'b0, ADDR_C, 32'd0, e);
      n_cmp++;
      if (o.rdata !== 32'd7 || o.err !== 1'b0 || o !== e) begin
         n_err++; $display("FAIL wait_read: got %s want %s", show(o), show(e));
      end
   endtask

   task automatic test_unmapped();
      obs_t o, e;
      xfer(1, 1'b1, 32'h12340000, 32'd9, o);
      model_xfer(1, 1'b1, 32'h12340000, 32'd9, e);
      n_cmp++;
      if (o.err !== 1'b1 || o.strobe !== 3'b000 || o.c !== 32'd7 || o !== e) begin
         n_err++; $display("FAIL unmapped_wr: got %s want %s", show(o), show(e));
      end
      xfer(1, 1'b0, 32'h12340000, 32'd0, o);
      model_xfer(1, 1'b0, 32'h12340000, 32'd0, e);
      n_cmp++;
      if (o.err !== 1'b1 || o.rdata !== 32'h0 || o !== e) begin
         n_err++; $display("FAIL unmapped_rd: got %s want %s", show(o), show(e));
      end
   endtask

   task automatic test_overflow();
      obs_t o, e;
      logic [31:0] exp_b;
`ifdef APB_SINK_SATURATE_EN
      exp_b = 32'hFFFFFFFF;
`else
      exp_b = 32'h00000001;
`endif
      xfer(0, 1'b1, ADDR_B, 32'hFFFFFFFF, o);
      model_xfer(0, 1'b1, ADDR_B, 32'hFFFFFFFF, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ovf_preload: got %s want %s", show(o), show(e)); end
      xfer(0, 1'b1, ADDR_B, 32'd2, o);
      model_xfer(0, 1'b1, ADDR_B, 32'd2, e);
      n_cmp++;
      if (o.b !== exp_b || o !== e) begin
         n_err++; $display("FAIL ovf_add: got b=%h want b=%h (%s)", o.b, exp_b, show(e));
      end
      xfer(0, 1'b1, ADDR_B, 32'd0, o);
      model_xfer(0, 1'b1, ADDR_B, 32'd0, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL ovf_zero: got %s want %s", show(o), show(e)); end
   endtask

   task automatic test_protocol();
      obs_t o, e;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = ADDR_A; pwdata[2] = 32'd11;
      @(negedge clk);
      penable[2] = 1'b1;
      @(negedge clk);
      psel[2] = 1'b0; penable[2] = 1'b0;
      @(negedge clk);
      m_perr[2] = 1'b1;
      n_cmp++;
      if (perr[2] !== 1'b1 || pready[2] !== 1'b0) begin
         n_err++; $display("FAIL abort_flag: got perr=%b rdy=%b want perr=1 rdy=0", perr[2], pready[2]);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (perr[2] !== 1'b1 || a_tot[2] !== m_tot[2][0] || strobe[2] !== 3'b000) begin
         n_err++; $display("FAIL abort_sticky: got perr=%b a=%h stb=%b want perr=1 a=%h stb=000",
                           perr[2], a_tot[2], strobe[2], m_tot[2][0]);
      end
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = ADDR_A; pwdata[0] = 32'd5;
      @(negedge clk);
      psel[0] = 1'b0; penable[0] = 1'b0;
      n_cmp++;
      if (pready[0] !== 1'b0) begin n_err++; $display("FAIL nosetup_rdy: got rdy=%b want 0", pready[0]); end
      @(negedge clk);
      m_perr[0] = 1'b1;
      n_cmp++;
      if (perr[0] !== 1'b1 || a_tot[0] !== m_tot[0][0] || strobe[0] !== 3'b000 || pready[0] !== 1'b0) begin
         n_err++; $display("FAIL nosetup_flag: got perr=%b a=%h stb=%b rdy=%b want perr=1 a=%h stb=000 rdy=0",
                           perr[0], a_tot[0], strobe[0], pready[0], m_tot[0][0]);
      end
      xfer(0, 1'b1, ADDR_C, 32'd4, o);
      model_xfer(0, 1'b1, ADDR_C, 32'd4, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL after_err: got %s want %s", show(o), show(e)); end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = ADDR_A; pwdata[2] = 32'd20;
      @(negedge clk);
      penable[2] = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         n_cmp++;
         if ({pready[d], a_tot[d], b_tot[d], c_tot[d], strobe[d], perr[d]} !== '0) begin
            n_err++; $display("FAIL midreset_d%0d: got rdy=%b a=%h b=%h c=%h stb=%b perr=%b want all zero",
                              d, pready[d], a_tot[d], b_tot[d], c_tot[d], strobe[d], perr[d]);
         end
      end
      model_clear();
      reset = 1'b0;
      psel[2] = 1'b0; penable[2] = 1'b0;
      xfer(2, 1'b1, ADDR_A, 32'd20, o);
      model_xfer(2, 1'b1, ADDR_A, 32'd20, e);
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midreset_next: got %s want %s", show(o), show(e)); end
   endtask

   task automatic test_random();
      obs_t o, e;
      logic [31:0] addr, data;
      logic wr;
      for (int d = 0; d < N; d++) begin
         for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
               0: addr = ADDR_A;
               1: addr = ADDR_B;
               2: addr = ADDR_C;
               default: begin
                  addr = $urandom();
                  if (decode(addr) >= 0) addr = 32'h12340000;
               end
            endcase
            wr   = 1'($urandom_range(0, 1));
            data = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 100)) : $urandom();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xfer(d, wr, addr, data, o);
            model_xfer(d, wr, addr, data, e);
            n_cmp++;
            if (o !== e) begin
               n_err++;
               $display("FAIL rand_d%0d_i%0d wr=%b addr=%h data=%h: got %s want %s", d, i, wr, addr, data, show(o), show(e));
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < N; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; paddr[d] = 32'h0; pwrite[d] = 1'b0; pwdata[d] = 32'h0;
      end
      model_clear();
      test_reset();
      test_basic_write();
      test_wait_states();
      test_unmapped();
      test_overflow();
      test_protocol();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
